regfile_wb: RTL and testbench

- Integer register file that terminates the write-back stage. It consumes the rd write-enable, address and data driven out of wb each cycle.
- Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard. Decode marks a destination busy at issue; the matching wb write clears it. This lets decode detect RAW hazards.
- Sits between wb (write side) and id (read/issue side).

---
 rtl/regfile_wb_pkg.sv | 26 ++
 rtl/rf_scoreboard.sv | 76 +++++++
 rtl/regfile_wb.sv | 76 +++++++
 tb/tb_regfile_wb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths and helpers for the write-back register file and its
// pending-write scoreboard.
package regfile_wb_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int PEND_W   = 2;
  localparam int REG_NUM  = 32;
  localparam int ZERO_REG = 0;

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  // x0 is hardwired: it is never stored, never busy and never counted.
  function automatic logic is_live_addr(input logic [REG_AW-1:0] addr);
    return addr != REG_AW'(ZERO_REG);
  endfunction

  // A register whose last outstanding write retires this cycle is not busy.
  function automatic logic pend_busy(input logic [PEND_W-1:0] cnt,
                                     input logic              retiring);
    return (cnt > PEND_ONE) || ((cnt == PEND_ONE) && !retiring);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: decode increments at issue, write-back
// decrements on retirement; drives busy and issue-ready.
module rf_scoreboard
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic              i_issue_en,
  input  logic [REG_AW-1:0] i_issue_addr,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_issue_ready
);

  logic [PEND_W-1:0] r_cnt     [1:REG_NUM-1];
  logic [PEND_W-1:0] w_cnt     [REG_NUM];
  logic [PEND_W-1:0] w_cnt_nxt [1:REG_NUM-1];
  logic              w_dec_vld;
  logic              w_inc_vld;
  logic              w_issue_ret;
  logic [REG_NUM-1:1] w_inc_hit;
  logic [REG_NUM-1:1] w_dec_hit;

  // Zero-extended view so x0 can be indexed like any other register.
  always_comb begin
    w_cnt[0] = PEND_ZERO;
    for (int i = 1; i < REG_NUM; i++) begin
      w_cnt[i] = r_cnt[i];
    end
  end

  // Retirement, issue acceptance, busy and ready; reset forces idle outputs.
  always_comb begin
    w_dec_vld     = !rst && i_wb_en && is_live_addr(i_wb_addr);
    w_issue_ret   = w_dec_vld && (i_wb_addr == i_issue_addr);
    o_issue_ready = rst || !is_live_addr(i_issue_addr) ||
                    !((w_cnt[i_issue_addr] == PEND_MAX) && !w_issue_ret);
    w_inc_vld     = !rst && i_issue_en && o_issue_ready && is_live_addr(i_issue_addr);
    o_rs1_busy    = !rst && is_live_addr(i_rs1_addr) &&
                    pend_busy(w_cnt[i_rs1_addr], w_dec_vld && (i_wb_addr == i_rs1_addr));
    o_rs2_busy    = !rst && is_live_addr(i_rs2_addr) &&
                    pend_busy(w_cnt[i_rs2_addr], w_dec_vld && (i_wb_addr == i_rs2_addr));
  end

  // Next count per register; a decrement at zero holds rather than wrapping.
  always_comb begin
    for (int i = 1; i < REG_NUM; i++) begin
      w_inc_hit[i] = w_inc_vld && (i_issue_addr == REG_AW'(i));
      w_dec_hit[i] = w_dec_vld && (i_wb_addr == REG_AW'(i));
      case ({w_inc_hit[i], w_dec_hit[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + PEND_ONE;
        2'b01:   w_cnt_nxt[i] = (r_cnt[i] == PEND_ZERO) ? PEND_ZERO : r_cnt[i] - PEND_ONE;
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    for (int i = 1; i < REG_NUM; i++) begin
      if (rst) begin
        r_cnt[i] <= PEND_ZERO;
      end else begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    w_dec_vld |-> (w_cnt[i_wb_addr] != PEND_ZERO));

endmodule

// File: rtl/regfile_wb.sv
// Integer register file closing the write-back stage: 31 stored registers,
// two bypassed combinational read ports and a pending-write scoreboard.
module regfile_wb
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_rd_wr_en_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]   wb_rd_reg_data_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic              rs1_busy_o,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              rs2_busy_o,
  input  logic              issue_rd_en_i,
  input  logic [REG_AW-1:0] issue_rd_addr_i,
  output logic              issue_ready_o
);

  logic [XLEN-1:0] r_regs [1:REG_NUM-1];
  logic [XLEN-1:0] w_regs [REG_NUM];
  logic            w_wr_vld;

  assign w_wr_vld = !rst && wb_rd_wr_en_i && is_live_addr(wb_rd_addr_i);

  // Storage update; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    for (int i = 1; i < REG_NUM; i++) begin
      if (rst) begin
        r_regs[i] <= {XLEN{1'b0}};
      end else if (w_wr_vld && (wb_rd_addr_i == REG_AW'(i))) begin
        r_regs[i] <= wb_rd_reg_data_i;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Read view with x0 hardwired to zero.
  always_comb begin
    w_regs[0] = {XLEN{1'b0}};
    for (int i = 1; i < REG_NUM; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  // Read ports: reset reads zero, a same-cycle write is forwarded.
  always_comb begin
    if (rst) begin
      rs1_data_o = {XLEN{1'b0}};
      rs2_data_o = {XLEN{1'b0}};
    end else begin
      rs1_data_o = (w_wr_vld && (wb_rd_addr_i == rs1_addr_i)) ? wb_rd_reg_data_i
                                                              : w_regs[rs1_addr_i];
      rs2_data_o = (w_wr_vld && (wb_rd_addr_i == rs2_addr_i)) ? wb_rd_reg_data_i
                                                              : w_regs[rs2_addr_i];
    end
  end

  rf_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_wb_en       (wb_rd_wr_en_i),
    .i_wb_addr     (wb_rd_addr_i),
    .i_issue_en    (issue_rd_en_i),
    .i_issue_addr  (issue_rd_addr_i),
    .i_rs1_addr    (rs1_addr_i),
    .i_rs2_addr    (rs2_addr_i),
    .o_rs1_busy    (rs1_busy_o),
    .o_rs2_busy    (rs2_busy_o),
    .o_issue_ready (issue_ready_o)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized
// traffic checked against an array/count reference model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  a1, a2;
  logic [31:0] d1, d2;
  logic        b1, b2;
  logic        ien;
  logic [4:0]  iaddr;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  int          m_cnt [32];

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk              (clk),
    .rst              (rst),
    .wb_rd_wr_en_i    (wen),
    .wb_rd_addr_i     (waddr),
    .wb_rd_reg_data_i (wdata),
    .rs1_addr_i       (a1),
    .rs1_data_o       (d1),
    .rs1_busy_o       (b1),
    .rs2_addr_i       (a2),
    .rs2_data_o       (d2),
    .rs2_busy_o       (b2),
    .issue_rd_en_i    (ien),
    .issue_rd_addr_i  (iaddr),
    .issue_ready_o    (rdy)
  );

  // ---------------- reference model ----------------
  function automatic logic m_retire(input logic [4:0] a);
    return !rst && wen && (waddr == a) && (a != 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (wen && waddr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (rst || a == 5'd0) return 1'b0;
    return (m_cnt[a] - (m_retire(a) ? 1 : 0)) > 0;
  endfunction

  function automatic logic exp_ready();
    if (rst || iaddr == 5'd0) return 1'b1;
    return !(m_cnt[iaddr] == 3 && !m_retire(iaddr));
  endfunction

  task automatic tick();
    logic inc, dec;
    inc = !rst && ien && (iaddr != 5'd0) && exp_ready();
    dec = !rst && wen && (waddr != 5'd0);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 32'd0;
        m_cnt[i] = 0;
      end
    end else begin
      if (dec) m_reg[waddr] = wdata;
      if (inc) m_cnt[iaddr] = m_cnt[iaddr] + 1;
      if (dec && m_cnt[waddr] > 0) m_cnt[waddr] = m_cnt[waddr] - 1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wen = 1'b0; waddr = 5'd0; wdata = 32'd0;
    a1 = 5'd0; a2 = 5'd0; ien = 1'b0; iaddr = 5'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 32'hA5A5_A5A5;
    ien = 1'b1; iaddr = 5'd5; a1 = 5'd5;
    #2;
    checks++; if (d1 !== 32'd0) begin errors++; $display("FAIL reset_during_data got %h exp %h", d1, 32'd0); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_during_ready got %b exp 1", rdy); end
    tick();
    tick();
    idle(); a1 = 5'd5; a2 = 5'd0;
    #2;
    checks++; if (d1 !== 32'd0 || d2 !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", d1, d2); end
    checks++; if (b1 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0/0", b1, b2); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); ien = 1'b1; iaddr = 5'd5;
    tick();
    idle(); wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; a1 = 5'd5;
    #2;
    checks++; if (d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_data got %h exp %h", d1, 32'hDEAD_BEEF); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp 0", b1); end
    tick();
    idle(); a1 = 5'd5;
    #2;
    checks++; if (d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_data got %h exp %h", d1, 32'hDEAD_BEEF); end
    tick();
  endtask

  task automatic test_x0();
    idle(); wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; a2 = 5'd0;
    ien = 1'b1; iaddr = 5'd0;
    #2;
    checks++; if (d2 !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h exp 0", d2); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", rdy); end
    tick();
    idle(); a1 = 5'd0; a2 = 5'd0;
    #2;
    checks++; if (d2 !== 32'd0) begin errors++; $display("FAIL x0_stored got %h exp 0", d2); end
    checks++; if (b1 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL x0_busy got %b/%b exp 0/0", b1, b2); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle(); ien = 1'b1; iaddr = 5'd7;
    tick();
    idle(); a1 = 5'd7;
    #2;
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL sb_busy_after_issue got %b exp 1", b1); end
    tick();
    idle(); a1 = 5'd7; wen = 1'b1; waddr = 5'd7; wdata = 32'h0000_0012;
    #2;
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL sb_busy_retire got %b exp 0", b1); end
    checks++; if (d1 !== 32'h0000_0012) begin errors++; $display("FAIL sb_retire_data got %h exp 12", d1); end
    tick();
    idle(); a1 = 5'd7; a2 = 5'd7;
    #2;
    checks++; if (b1 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL sb_busy_after got %b/%b exp 0/0", b1, b2); end
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      idle(); ien = 1'b1; iaddr = 5'd3;
      #2;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d got %b exp 1", k, rdy); end
      tick();
    end
    idle(); ien = 1'b1; iaddr = 5'd3;
    #2;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sat_full got %b exp 0", rdy); end
    tick();
    idle(); ien = 1'b1; iaddr = 5'd3; wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    #2;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sat_ready_with_retire got %b exp 1", rdy); end
    tick();
    idle(); ien = 1'b1; iaddr = 5'd3; a1 = 5'd3;
    #2;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sat_still_full got %b exp 0", rdy); end
    checks++; if (m_cnt[3] != 3) begin errors++; $display("FAIL sat_model_count got %0d exp 3", m_cnt[3]); end
    tick();
  endtask

  task automatic test_reset_midop();
    idle(); wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0077;
    tick();
    idle(); ien = 1'b1; iaddr = 5'd9;
    tick();
    idle(); a1 = 5'd9; a2 = 5'd3;
    #2;
    checks++; if (b1 !== 1'b1 || b2 !== 1'b1) begin errors++; $display("FAIL midop_pre_busy got %b/%b exp 1/1", b1, b2); end
    rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
    tick();
    idle(); a1 = 5'd9; a2 = 5'd3;
    #2;
    checks++; if (b1 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL midop_busy got %b/%b exp 0/0", b1, b2); end
    checks++; if (d1 !== 32'd0) begin errors++; $display("FAIL midop_x9 got %h exp 0", d1); end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int n = 0; n < 400; n++) begin
      idle();
      rst   = ($urandom_range(0, 49) == 0);
      ien   = $urandom_range(0, 1) == 1;
      iaddr = 5'($urandom_range(0, 7));
      a     = 5'($urandom_range(0, 7));
      wen   = ($urandom_range(0, 1) == 1) && (a == 5'd0 || m_cnt[a] > 0 || rst);
      waddr = a;
      wdata = $urandom;
      a1    = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom_range(0, 7));
      a2    = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      #2;
      checks++; if (d1 !== exp_data(a1)) begin errors++; $display("FAIL rnd_d1 cyc %0d got %h exp %h", n, d1, exp_data(a1)); end
      checks++; if (d2 !== exp_data(a2)) begin errors++; $display("FAIL rnd_d2 cyc %0d got %h exp %h", n, d2, exp_data(a2)); end
      checks++; if (b1 !== exp_busy(a1)) begin errors++; $display("FAIL rnd_b1 cyc %0d got %b exp %b", n, b1, exp_busy(a1)); end
      checks++; if (b2 !== exp_busy(a2)) begin errors++; $display("FAIL rnd_b2 cyc %0d got %b exp %b", n, b2, exp_busy(a2)); end
      checks++; if (rdy !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, rdy, exp_ready()); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0;
      m_cnt[i] = 0;
    end
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_saturation();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
